// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_FRAME_BITS = 10;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes ahead of the serialiser.
// Head entry is visible combinationally on pop_data while not empty.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   push,
  output logic                   full,
  input  logic                   pop,
  output logic [DATA_W-1:0]      pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  // Full is taken from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];
  assign level    = count;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array carries no reset; stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: buffered bytes are framed and shifted out
// LSB first, CLKS_PER_BIT clocks per bit, line idling high.
module uart_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  import uart_pkg::*;

  localparam int                          TW       = $clog2(CLKS_PER_BIT);
  localparam int                          BW       = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0]               TMAX     = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]               LAST_BIT = BW'(UART_DATA_BITS - 1);

  uart_tx_state_t              state;
  uart_tx_state_t              state_nxt;
  logic [TW-1:0]               timer;
  logic [TW-1:0]               timer_nxt;
  logic [BW-1:0]               bit_cnt;
  logic [BW-1:0]               bit_cnt_nxt;
  logic [UART_DATA_BITS-1:0]   shift;
  logic [UART_DATA_BITS-1:0]   shift_nxt;
  logic                        tx_q;
  logic                        tx_nxt;
  logic                        pop;
  logic                        bit_end;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [UART_DATA_BITS-1:0]   fifo_data;

  uart_tx_fifo #(
    .DATA_W (UART_DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_data (in_data),
    .push      (in_valid),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign bit_end  = (timer == TMAX);
  assign in_ready = ~fifo_full;
  assign busy     = (state != IDLE) | ~fifo_empty;
  assign tx       = tx_q;

  // Next-state, line level and pop decision for the framing FSM.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = bit_end ? '0 : timer + 1'b1;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    tx_nxt      = tx_q;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        tx_nxt    = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_data;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_nxt      = shift[0];
          bit_cnt_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == LAST_BIT) begin
            tx_nxt    = UART_IDLE_LEVEL;
            state_nxt = STOP;
          end else begin
            // shift[1] becomes the new shift[0] on this edge
            shift_nxt   = shift >> 1;
            tx_nxt      = shift[1];
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // chain straight into the next start bit, no idle gap
            pop       = 1'b1;
            shift_nxt = fifo_data;
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        tx_nxt    = UART_IDLE_LEVEL;
        state_nxt = IDLE;
      end
    endcase
  end

  // Control state; reset truncates any frame and returns the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      tx_q    <= UART_IDLE_LEVEL;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_q    <= tx_nxt;
    end
  end

  // Shift register is pure data and only meaningful once loaded on a pop.
  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued as expectations,
// a line monitor decodes every frame on tx and compares against the queue.
module tb_uart_tx;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;

  int         cyc = 0;
  int         busy_cnt = 0;
  int         checks = 0;
  int         passed = 0;
  logic [7:0] exp_q[$];
  int         start_cyc[$];

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (busy === 1'b1) busy_cnt <= busy_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present a byte and hold it until the handshake completes; acc is the
  // edge count at which the byte was taken.
  task automatic push_byte(input logic [7:0] b, output int acc);
    int budget;
    budget   = 0;
    acc      = -1;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      $display("FAIL push_timeout: byte %0h never accepted, in_ready %b", b, in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      exp_q.push_back(b);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || exp_q.size() != 0) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: busy %b, %0d frames outstanding", busy, exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Line monitor: every sample of a frame must hold the level of its bit.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] want;
    int         bad;
    int         idx;
    int         pos;
    bit         abort;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      start_cyc.push_back(cyc);
      bad   = 0;
      abort = 0;
      got   = '0;
      for (int s = 1; s < 10 * CPB; s++) begin
        @(negedge clk);
        if (rst !== 1'b0) begin
          abort = 1;
          break;
        end
        idx = s / CPB;
        pos = s % CPB;
        if (idx == 0) begin
          if (tx !== 1'b0) bad++;
        end else if (idx <= 8) begin
          if (pos == 0) got[idx-1] = tx;
          else if (tx !== got[idx-1]) bad++;
        end else begin
          if (tx !== 1'b1) bad++;
        end
      end
      if (!abort) begin
        check("frame_bit_timing", bad, 0);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_frame: got %0h expected no frame", got);
        end else begin
          want = exp_q.pop_front();
          check("frame_data", got, want);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int e, e1, e2, e3, e4, e5, s0, bz0, n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_level", fifo_level, 0);
    @(posedge clk);
    #1;

    // Single byte: one-cycle pop latency, 80-cycle frame, busy drops at end.
    push_byte(8'hA5, e);
    @(negedge clk);
    check("a5_level_after_accept", fifo_level, 1);
    check("a5_tx_before_pop", tx, 1);
    @(negedge clk);
    check("a5_start_bit", tx, 0);
    check("a5_level_after_pop", fifo_level, 0);
    wait_until(e + 80);
    @(negedge clk);
    check("a5_busy_last_stop_cycle", busy, 1);
    wait_until(e + 81);
    @(negedge clk);
    check("a5_busy_after_frame", busy, 0);
    check("a5_tx_idle_after_frame", tx, 1);
    drain();

    // Burst with valid held: first byte pops on the edge after it lands,
    // so occupancy peaks at 2; frames chain 80 cycles apart.
    s0  = start_cyc.size();
    bz0 = busy_cnt;
    push_byte(8'h00, e);
    push_byte(8'hFF, e1);
    push_byte(8'h55, e2);
    @(negedge clk);
    check("burst_level_peak", fifo_level, 2);
    check("burst_accepts_consecutive", e2 - e, 2);
    drain();
    check("burst_gap_0_1", start_cyc[s0+1] - start_cyc[s0], 80);
    check("burst_gap_1_2", start_cyc[s0+2] - start_cyc[s0+1], 80);
    // one pre-pop cycle plus three back-to-back 80-cycle frames
    check("burst_busy_cycles", busy_cnt - bz0, 241);

    // Six bytes into a 4-deep FIFO: the sixth stalls until the first STOP pop
    // at E+81, then is taken on the following edge.
    push_byte(8'h10, e);
    push_byte(8'h11, e1);
    push_byte(8'h12, e2);
    push_byte(8'h13, e3);
    push_byte(8'h14, e4);
    @(negedge clk);
    check("full_level", fifo_level, 4);
    check("full_in_ready", in_ready, 0);
    push_byte(8'h15, e5);
    check("stall_release_cycle", e5 - e, 82);
    drain();

    // Loopback pair.
    push_byte(8'h3C, e);
    push_byte(8'hC3, e1);
    drain();

    // Push lands on the same edge as the STOP pop: level stays at 1.
    push_byte(8'h5A, e);
    push_byte(8'hA6, e1);
    wait_until(e + 80);
    push_byte(8'h99, e2);
    check("pushpop_accept_cycle", e2 - e, 81);
    @(negedge clk);
    check("pushpop_level", fifo_level, 1);
    check("pushpop_next_start", tx, 0);
    drain();

    // Reset during data bit 3 of 0x81 with two bytes queued, plus a
    // handshake offered in the reset cycle itself.
    push_byte(8'h81, e);
    push_byte(8'h42, e1);
    push_byte(8'h24, e2);
    wait_until(e + 36);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_tx", tx, 1);
    check("rst_mid_level", fifo_level, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_busy", busy, 0);
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) n++;
    end
    check("no_frames_after_reset", n, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
